ctr_sched: RTL and testbench
============================

CTR_SCHED -- requirements
Module: ctr_sched

Interface
REQ-001 SHALL have parameters: AES_LATENCY, default 20, cycles from aes_in capture to valid AES output; OUT_DEPTH, default 16, output FIFO entries.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle job launch.
REQ-005 number_blocks  input  16  blocks in the job; sampled on accepted start.
REQ-006 ctr_iv  input  128  initial counter; sampled on accepted start.
REQ-007 in_avail  input  1  input data FIFO non-empty.
REQ-008 out_pop  input  1  downstream popped one output FIFO entry (credit return).
REQ-009 in_read_en  output  1  pop input data FIFO into alignment FIFO.
REQ-010 aes_in  output  128  counter block to the AES core.
REQ-011 align_read_en  output  1  pop alignment FIFO (registered-read FIFO).
REQ-012 out_write_en  output  1  write (data ^ keystream) to output FIFO.
REQ-013 busy  output  1  job in progress.
REQ-014 done  output  1  job complete; held until next accepted start.
REQ-015 blocks_retired  output  16  blocks written to the output FIFO in the current job.

Function
REQ-016 States SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-017 start in IDLE or DONE SHALL latch number_blocks into remaining, clear the counter offset and blocks_retired, deassert done, and go to ISSUE; go to DONE instead if number_blocks == 0.
REQ-018 start in ISSUE or DRAIN SHALL be ignored.
REQ-019 In ISSUE, an issue SHALL occur in any cycle where in_avail && credits > 0 && remaining > 0, sustaining one issue per cycle.
REQ-020 An issue SHALL register in_read_en = 1 and aes_in = ctr_iv + offset (mod 2^128, wrap permitted), then increment offset, decrement remaining and decrement credits.
REQ-021 In non-issue cycles, in_read_en SHALL be 0 and aes_in SHALL be 0.
REQ-022 credits SHALL reset to OUT_DEPTH, increment on out_pop, and remain unchanged when an issue and out_pop coincide.
REQ-023 credits SHALL saturate at OUT_DEPTH; an out_pop at OUT_DEPTH SHALL be ignored.
REQ-024 A valid shift register of AES_LATENCY stages SHALL track in-flight issues.
REQ-025 align_read_en SHALL pulse exactly AES_LATENCY-1 cycles after the cycle in which in_read_en is high.
REQ-026 out_write_en SHALL pulse exactly AES_LATENCY cycles after that same cycle.
REQ-027 blocks_retired SHALL increment on each out_write_en.
REQ-028 in_flight, a 6-bit count, SHALL increment on issue, decrement on out_write_en, and remain unchanged when both occur in the same cycle.
REQ-029 ISSUE SHALL go to DRAIN in the cycle after remaining reaches 0.
REQ-030 DRAIN SHALL go to DONE when in_flight == 0.
REQ-031 busy SHALL be 1 in ISSUE and DRAIN only; done SHALL be 1 in DONE only.
REQ-032 Credits SHALL persist across jobs and SHALL NOT be reset by start.

Reset
REQ-033 reset_n low SHALL immediately force IDLE and clear all outputs, counters, the valid pipe and in_flight, and set credits to OUT_DEPTH.
REQ-034 Reset mid-job SHALL discard in-flight blocks; no out_write_en SHALL follow reset release without a new issue.

Structure
REQ-035 State encodings, AES key-size codes and the default AES_LATENCY SHALL reside in shared package ctr_pkg.
REQ-036 The valid pipe SHALL be the sub-module ctr_delay_line, parameterized by depth, with async active-low reset.

Verification
REQ-037 number_blocks=4, ctr_iv=0x10, in_avail=1, credits full -> aes_in 0x10,0x11,0x12,0x13 on consecutive cycles; out_write_en 20 cycles after each; done after the 4th write.
REQ-038 ctr_iv=all-ones, number_blocks=2 -> aes_in all-ones then 0 (wrap).
REQ-039 number_blocks=20 with no out_pop -> exactly 16 issues, then stall; out_pop pulses resume issue one-for-one; 20 writes total.
REQ-040 in_avail toggling 1/0 each cycle, number_blocks=6 -> issues only in in_avail cycles; align_read_en/out_write_en spacing 19/20 cycles preserved.
REQ-041 reset_n low 5 cycles after start with number_blocks=8 -> all outputs 0 immediately; no out_write_en after release; a following start with number_blocks=0 -> DONE next cycle, blocks_retired=0.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared definitions for the CTR-mode scheduler: FSM states, AES key-size codes, defaults.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ctr_pkg;

  localparam int DEF_AES_LATENCY = 20;
  localparam int DEF_OUT_DEPTH   = 16;
  localparam int CNT_W           = 16;
  localparam int BLK_W           = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    AES_KEY_128 = 2'd0,
    AES_KEY_192 = 2'd1,
    AES_KEY_256 = 2'd2
  } aes_key_t;

endpackage

// File: rtl/ctr_sched_if.sv
// Job-control and datapath-steering bundle between the scheduler and its surroundings.
// Latency: none (wiring only).
// Backpressure: output FIFO credits return on out_pop; input availability on in_avail.
interface ctr_sched_if;
  import ctr_pkg::*;

  logic             start;
  logic [CNT_W-1:0] number_blocks;
  logic [BLK_W-1:0] ctr_iv;
  logic             in_avail;
  logic             out_pop;
  logic             in_read_en;
  logic [BLK_W-1:0] aes_in;
  logic             align_read_en;
  logic             out_write_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] blocks_retired;

  // Environment side: launches jobs, reports FIFO status, observes steering strobes.
  modport master (
    output start, number_blocks, ctr_iv, in_avail, out_pop,
    input  in_read_en, aes_in, align_read_en, out_write_en, busy, done, blocks_retired
  );

  // Scheduler side.
  modport slave (
    input  start, number_blocks, ctr_iv, in_avail, out_pop,
    output in_read_en, aes_in, align_read_en, out_write_en, busy, done, blocks_retired
  );

endinterface

// File: rtl/ctr_delay_line.sv
// Valid shift register tracking blocks in flight through the AES core.
// Latency: tap_prev is din delayed DEPTH-1 cycles, tap_last DEPTH cycles (DEPTH >= 2).
// Backpressure: none; the pipe advances every cycle.
module ctr_delay_line #(
  parameter int DEPTH = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic tap_prev,
  output logic tap_last
);

  logic [DEPTH-1:0] pipe;

  // Shift one stage per cycle; reset drops every tracked block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[DEPTH-2:0], din};
    end
  end

  assign tap_prev = pipe[DEPTH-2];
  assign tap_last = pipe[DEPTH-1];

endmodule

// File: rtl/ctr_sched.sv
// CTR-mode job scheduler: issues counter blocks to AES and steers align/output FIFO strobes.
// Latency: aes_in/in_read_en 1 cycle after issue decision; align +AES_LATENCY-1, write +AES_LATENCY.
// Backpressure: issues stall when in_avail is low or no output FIFO credit remains.
module ctr_sched
  import ctr_pkg::*;
#(
  parameter int AES_LATENCY = DEF_AES_LATENCY,
  parameter int OUT_DEPTH   = DEF_OUT_DEPTH
) (
  input logic        clk,
  input logic        reset_n,
  ctr_sched_if.slave bus
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(OUT_DEPTH);
  localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [BLK_W-1:0] iv;
  logic [BLK_W-1:0] offset;
  logic [CW-1:0]    credits;
  logic [5:0]       in_flight;
  logic             in_read_en_q;
  logic [BLK_W-1:0] aes_in_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] retired_q;
  logic             align_q;
  logic             write_q;
  logic             issue;
  logic             pop_ok;

  // A block goes out only with input data present, room downstream, and work left.
  assign issue  = (state == ST_ISSUE) && bus.in_avail && (credits != '0) && (remaining != '0);
  // A credit return beyond the FIFO depth would be bogus, so it is dropped.
  assign pop_ok = bus.out_pop && (credits < CREDIT_MAX);

  // Job FSM with registered strobes, counter block and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      iv           <= '0;
      offset       <= '0;
      in_read_en_q <= 1'b0;
      aes_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      retired_q    <= '0;
    end else begin
      in_read_en_q <= issue;
      aes_in_q     <= issue ? (iv + offset) : '0;
      if (write_q) begin
        retired_q <= retired_q + 16'd1;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            remaining <= bus.number_blocks;
            iv        <= bus.ctr_iv;
            offset    <= '0;
            retired_q <= '0;
            if (bus.number_blocks == 16'd0) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state  <= ST_ISSUE;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          if (remaining == 16'd0) begin
            state <= ST_DRAIN;
          end else if (issue) begin
            offset    <= offset + 128'd1;
            remaining <= remaining - 16'd1;
          end
        end
        ST_DRAIN: begin
          if (in_flight == 6'd0) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output FIFO credits: persist across jobs; a coincident issue and pop cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits <= CREDIT_MAX;
    end else if (issue && !pop_ok) begin
      credits <= credits - CREDIT_ONE;
    end else if (!issue && pop_ok) begin
      credits <= credits + CREDIT_ONE;
    end
  end

  // Blocks issued but not yet written; DRAIN waits for this to empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_flight <= '0;
    end else if (issue && !write_q) begin
      in_flight <= in_flight + 6'd1;
    end else if (!issue && write_q) begin
      in_flight <= in_flight - 6'd1;
    end
  end

  ctr_delay_line #(
    .DEPTH(AES_LATENCY)
  ) u_vld_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (in_read_en_q),
    .tap_prev (align_q),
    .tap_last (write_q)
  );

  assign bus.in_read_en     = in_read_en_q;
  assign bus.aes_in         = aes_in_q;
  assign bus.align_read_en  = align_q;
  assign bus.out_write_en   = write_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.blocks_retired = retired_q;

endmodule

// File: tb/tb_ctr_sched.sv
// Self-checking bench for ctr_sched: job table, randomized jobs, reset-mid-job sequence.
// Latency: outputs checked every cycle, 1 time unit after the rising edge.
// Backpressure: bench acts as the output FIFO consumer, popping only entries it holds.
module tb_ctr_sched;

  localparam int L     = 20;
  localparam int DEPTH = 16;
  localparam int BUDGET = 4000;

  typedef struct {
    logic [15:0]  nb;
    logic [127:0] iv;
    int           av_mode;      // 0 always, 1 toggle, 2 random
    int           hold;         // cycles before the consumer starts popping (0 = random pops)
    logic [127:0] exp_first;
    logic [127:0] exp_last;
    int           exp_blocks;
    int           exp_hold_issued;  // -1 when not checked
  } vec_t;

  logic clk;
  logic reset_n;

  ctr_sched_if bus();

  ctr_sched #(
    .AES_LATENCY(L),
    .OUT_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int occ   = 0;

  // Reference model: job bookkeeping in plain integers plus a history of issued blocks.
  logic [127:0] rd_hist [int];
  bit           m_active;
  bit           m_done;
  int           m_done_at;
  int           m_remaining;
  int           m_credits;
  int           m_outstanding;
  int           m_retired;
  logic [127:0] m_iv;
  logic [127:0] m_offset;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    rd_hist.delete();
    m_active = 0; m_done = 0; m_done_at = -1;
    m_remaining = 0; m_credits = DEPTH; m_outstanding = 0; m_retired = 0;
    m_iv = '0; m_offset = '0;
    occ = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_read_en"},  128'(bus.in_read_en), 128'(0));
    chk({tag, "_aes_in"},      bus.aes_in, 128'(0));
    chk({tag, "_align"},       128'(bus.align_read_en), 128'(0));
    chk({tag, "_write"},       128'(bus.out_write_en), 128'(0));
    chk({tag, "_busy"},        128'(bus.busy), 128'(0));
    chk({tag, "_done"},        128'(bus.done), 128'(0));
    chk({tag, "_retired"},     128'(bus.blocks_retired), 128'(0));
  endtask

  // One clock: drive inputs, advance the model, then compare every output.
  task automatic tick(input bit st, input logic [15:0] nb, input logic [127:0] iv,
                      input bit av, input bit pop);
    bit issue, acc, pop_eff, wr_now;
    bit exp_rd, exp_wr, exp_al;
    logic [127:0] exp_aes;
    bus.start = st; bus.number_blocks = nb; bus.ctr_iv = iv;
    bus.in_avail = av; bus.out_pop = pop;
    issue   = m_active && av && (m_credits > 0) && (m_remaining > 0);
    acc     = st && !m_active;
    pop_eff = pop && (m_credits < DEPTH);
    wr_now  = rd_hist.exists(cyc - L);
    @(posedge clk); #1;
    cyc++;
    if (issue) begin
      rd_hist[cyc] = m_iv + m_offset;
      m_offset = m_offset + 128'd1;
      m_remaining--;
      m_outstanding++;
    end
    if (issue && !pop_eff) m_credits--;
    else if (!issue && pop_eff) m_credits++;
    if (wr_now) begin
      m_retired++;
      m_outstanding--;
      if (m_active && m_remaining == 0 && m_outstanding == 0) m_done_at = cyc + 1;
    end
    if (acc) begin
      m_remaining = int'(nb); m_offset = '0; m_iv = iv; m_retired = 0; m_done_at = -1;
      m_active = (nb != 16'd0);
      m_done   = (nb == 16'd0);
    end
    if (m_done_at == cyc) begin
      m_active = 0; m_done = 1; m_done_at = -1;
    end
    exp_rd  = rd_hist.exists(cyc);
    exp_aes = exp_rd ? rd_hist[cyc] : 128'(0);
    exp_wr  = rd_hist.exists(cyc - L);
    exp_al  = rd_hist.exists(cyc - L + 1);
    chk("in_read_en",     128'(bus.in_read_en), 128'(exp_rd));
    chk("aes_in",         bus.aes_in, exp_aes);
    chk("align_read_en",  128'(bus.align_read_en), 128'(exp_al));
    chk("out_write_en",   128'(bus.out_write_en), 128'(exp_wr));
    chk("busy",           128'(bus.busy), 128'(m_active));
    chk("done",           128'(bus.done), 128'(m_done));
    chk("blocks_retired", 128'(bus.blocks_retired), 128'(m_retired));
  endtask

  // Run one job to completion, then drain the consumer so credits are full again.
  task automatic run_job(input logic [15:0] nb, input logic [127:0] iv, input int av_mode,
                         input int hold, output int n_rd, output int n_wr,
                         output logic [127:0] first_aes, output logic [127:0] last_aes,
                         output int rd_at_hold);
    int t;
    bit av, pop;
    n_rd = 0; n_wr = 0; first_aes = '0; last_aes = '0; rd_at_hold = -1;
    tick(1'b1, nb, iv, 1'b0, 1'b0);
    t = 0;
    while (!m_done && t < BUDGET) begin
      case (av_mode)
        0:       av = 1'b1;
        1:       av = (t % 2 == 0);
        default: av = ($urandom_range(0, 1) == 1);
      endcase
      if (hold > 0) pop = (t >= hold) && (occ > 0);
      else          pop = (occ > 0) && ($urandom_range(0, 1) == 1);
      // A second start mid-job must be ignored.
      tick(t == 3, nb ^ 16'h0005, ~iv, av, pop);
      if (pop) occ--;
      if (bus.in_read_en) begin
        if (n_rd == 0) first_aes = bus.aes_in;
        last_aes = bus.aes_in;
        n_rd++;
      end
      if (bus.out_write_en) begin
        n_wr++;
        occ++;
      end
      if (t == hold) rd_at_hold = n_rd;
      t++;
    end
    if (t >= BUDGET) begin
      n_chk++; n_err++;
      $display("FAIL job_timeout: done not reached within %0d cycles (nb=%0d)", BUDGET, nb);
    end
    while (occ > 0) begin
      tick(1'b0, 16'd0, 128'd0, 1'b0, 1'b1);
      occ--;
    end
  endtask

  initial begin
    vec_t vecs[5];
    int n_rd, n_wr, rd_at_hold;
    logic [127:0] f_aes, l_aes;
    logic [15:0]  r_nb;
    logic [127:0] r_iv;

    vecs[0] = '{16'd4,  128'h10, 0, 0, 128'h10, 128'h13, 4, -1};
    vecs[1] = '{16'd2,  {128{1'b1}}, 0, 0, {128{1'b1}}, 128'h0, 2, -1};
    vecs[2] = '{16'd20, 128'h1000, 0, 60, 128'h1000, 128'h1013, 20, 16};
    vecs[3] = '{16'd6,  128'h55, 1, 0, 128'h55, 128'h5A, 6, -1};
    vecs[4] = '{16'd3,  128'hABCD_0000_0000_0000_0000_0000_FFFF_FFFE, 2, 0,
                128'hABCD_0000_0000_0000_0000_0000_FFFF_FFFE,
                128'hABCD_0000_0000_0000_0000_0001_0000_0000, 3, -1};

    reset_n = 1'b0;
    bus.start = 1'b0; bus.number_blocks = '0; bus.ctr_iv = '0;
    bus.in_avail = 1'b0; bus.out_pop = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Pops while credits are already full must be ignored.
    repeat (3) tick(1'b0, 16'd0, 128'd0, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].nb, vecs[i].iv, vecs[i].av_mode, vecs[i].hold,
              n_rd, n_wr, f_aes, l_aes, rd_at_hold);
      chk($sformatf("v%0d_issues", i), 128'(n_rd), 128'(vecs[i].exp_blocks));
      chk($sformatf("v%0d_writes", i), 128'(n_wr), 128'(vecs[i].exp_blocks));
      chk($sformatf("v%0d_first_aes", i), f_aes, vecs[i].exp_first);
      chk($sformatf("v%0d_last_aes", i), l_aes, vecs[i].exp_last);
      chk($sformatf("v%0d_done_held", i), 128'(bus.done), 128'(1));
      chk($sformatf("v%0d_retired", i), 128'(bus.blocks_retired), 128'(vecs[i].exp_blocks));
      if (vecs[i].exp_hold_issued >= 0)
        chk($sformatf("v%0d_issued_before_pop", i), 128'(rd_at_hold),
            128'(vecs[i].exp_hold_issued));
    end

    for (int j = 0; j < 6; j++) begin
      r_nb = 16'($urandom_range(0, 40));
      r_iv = {$urandom, $urandom, $urandom, $urandom};
      run_job(r_nb, r_iv, int'($urandom_range(0, 2)), 0, n_rd, n_wr, f_aes, l_aes, rd_at_hold);
      chk($sformatf("rnd%0d_writes", j), 128'(n_wr), 128'(r_nb));
      chk($sformatf("rnd%0d_retired", j), 128'(bus.blocks_retired), 128'(r_nb));
    end

    // Reset five cycles into an 8-block job: everything clears at once and nothing drains out.
    tick(1'b1, 16'd8, 128'h200, 1'b1, 1'b0);
    repeat (5) tick(1'b0, 16'd0, 128'd0, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midjob_reset");
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (30) tick(1'b0, 16'd0, 128'd0, 1'b1, 1'b0);
    tick(1'b1, 16'd0, 128'd0, 1'b0, 1'b0);
    chk("zero_job_done", 128'(bus.done), 128'(1));
    chk("zero_job_busy", 128'(bus.busy), 128'(0));
    chk("zero_job_retired", 128'(bus.blocks_retired), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
